pipelined_control_unit: RTL and testbench

- Next-generation main control for the 5-stage RISC-V pipeline.
- Decodes the IF/ID instruction fields and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, so each stage gets its own controls.
- Adds what the flat decoder lacks: load-use stall detection, branch flush, defined all-zero controls on illegal opcodes, optional JAL/JALR, and a selectable I-type ALUOp mode.

---
 rtl/pipelined_control_unit.sv | 163 ++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Main control for a 5-stage RISC-V pipeline: ID-stage decode, load-use stall,
// branch flush, and per-stage control registers for ID/EX, EX/MEM and MEM/WB.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned EN_JUMP     = 1,
  parameter int unsigned ALU_I_FUNCT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_branch,
  output logic                  mem_jump,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal_o
);

  typedef struct packed {
    logic                  alu_src;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  ex_ctrl_t  id_ex;
  mem_ctrl_t ex_mem;
  wb_ctrl_t  mem_wb;
  logic      dec_illegal;
  logic      use_rs1;
  logic      use_rs2;
  logic      hazard;
  logic      bubble_id;
  logic      illegal_q;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (id_opcode)
      7'b0110011: begin
        dec.alu_op = ALUOP_W'(2'b10); dec.reg_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0000011: begin
        dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        dec.wb_sel = 2'b01; use_rs1 = 1'b1;
      end
      7'b0010011: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; use_rs1 = 1'b1;
        dec.alu_op  = (ALU_I_FUNCT != 0) ? ALUOP_W'(2'b11) : ALUOP_W'(2'b00);
      end
      7'b0100011: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec.alu_op = ALUOP_W'(2'b01); dec.branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1101111: begin
        if (EN_JUMP != 0) begin
          dec.jump = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = 2'b10;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b1100111: begin
        if (EN_JUMP != 0) begin
          dec.alu_src = 1'b1; dec.jump = 1'b1; dec.reg_write = 1'b1;
          dec.wb_sel = 2'b10; use_rs1 = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // x0 is never written, and a non-writing instruction carries rd=0 so it cannot hazard.
    if (dec.reg_write && id_rd == '0) dec.reg_write = 1'b0;
    dec.rd = dec.reg_write ? id_rd : '0;
  end

  assign hazard = id_ex.mem_read && (id_ex.rd != '0) &&
                  ((use_rs1 && id_ex.rd == id_rs1) || (use_rs2 && id_ex.rd == id_rs2));
  assign stall_o   = hazard && !flush_i;
  assign bubble_id = stall_o || flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex     <= '0;
      ex_mem    <= '0;
      mem_wb    <= '0;
      illegal_q <= 1'b0;
    end else begin
      id_ex <= bubble_id ? '0 : dec;
      if (flush_i) begin
        ex_mem <= '0;
      end else begin
        ex_mem.branch    <= id_ex.branch;
        ex_mem.jump      <= id_ex.jump;
        ex_mem.mem_read  <= id_ex.mem_read;
        ex_mem.mem_write <= id_ex.mem_write;
        ex_mem.reg_write <= id_ex.reg_write;
        ex_mem.wb_sel    <= id_ex.wb_sel;
        ex_mem.rd        <= id_ex.rd;
      end
      // The flushing branch/jump already sits in EX/MEM, so it always retires.
      mem_wb.reg_write <= ex_mem.reg_write;
      mem_wb.wb_sel    <= ex_mem.wb_sel;
      mem_wb.rd        <= ex_mem.rd;
      if (!bubble_id && dec_illegal) illegal_q <= 1'b1;
    end
  end

  assign ex_alu_src   = id_ex.alu_src;
  assign ex_alu_op    = id_ex.alu_op;
  assign ex_rd        = id_ex.rd;
  assign mem_branch   = ex_mem.branch;
  assign mem_jump     = ex_mem.jump;
  assign mem_read     = ex_mem.mem_read;
  assign mem_write    = ex_mem.mem_write;
  assign mem_rd       = ex_mem.rd;
  assign wb_reg_write = mem_wb.reg_write;
  assign wb_sel       = mem_wb.wb_sel;
  assign wb_rd        = mem_wb.rd;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: default build (jumps on, add-only OP-IMM)
// alongside a second build with jumps off and funct3-decoded OP-IMM.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       flush_i;

  logic       stall_o, ex_alu_src, mem_branch, mem_jump, mem_read, mem_write;
  logic [1:0] ex_alu_op, wb_sel;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       wb_reg_write, illegal_o;

  logic       b_stall, b_ex_alu_src, b_mem_branch, b_mem_jump, b_mem_read, b_mem_write;
  logic [1:0] b_ex_alu_op, b_wb_sel;
  logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
  logic       b_wb_reg_write, b_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EN_JUMP(1), .ALU_I_FUNCT(0)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .flush_i(flush_i), .stall_o(stall_o), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_jump(mem_jump),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .illegal_o(illegal_o)
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EN_JUMP(0), .ALU_I_FUNCT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .flush_i(flush_i), .stall_o(b_stall), .ex_alu_src(b_ex_alu_src),
    .ex_alu_op(b_ex_alu_op), .ex_rd(b_ex_rd), .mem_branch(b_mem_branch), .mem_jump(b_mem_jump),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rd(b_mem_rd),
    .wb_reg_write(b_wb_reg_write), .wb_sel(b_wb_sel), .wb_rd(b_wb_rd), .illegal_o(b_illegal)
  );

  task automatic present(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
    id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic nop();
    present(OP_IMM, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; nop();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({ex_alu_src, ex_alu_op, ex_rd, mem_rd, wb_reg_write, wb_rd, illegal_o} !== '0) begin
      n_err++; $display("FAIL reset_initial: outputs not zero (ex_rd=%0d mem_rd=%0d wb_rd=%0d)", ex_rd, mem_rd, wb_rd); end
    rst_n = 1'b1;
    present(OP_R, 5'd3, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    n_vec++; if (mem_rd !== 5'd3) begin n_err++; $display("FAIL reset_pre_mem_rd: got %0d want 3", mem_rd); end
    n_vec++; if (ex_alu_src !== 1'b1) begin n_err++; $display("FAIL reset_pre_ex_alu_src: got %b want 1", ex_alu_src); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({ex_alu_src, ex_alu_op, ex_rd} !== '0) begin
      n_err++; $display("FAIL reset_async_ex: got src=%b op=%b rd=%0d want 0", ex_alu_src, ex_alu_op, ex_rd); end
    n_vec++; if ({mem_branch, mem_jump, mem_read, mem_write, mem_rd} !== '0) begin
      n_err++; $display("FAIL reset_async_mem: got rd=%0d want 0", mem_rd); end
    n_vec++; if ({wb_reg_write, wb_sel, wb_rd, illegal_o, stall_o} !== '0) begin
      n_err++; $display("FAIL reset_async_wb: got we=%b sel=%b rd=%0d ill=%b stall=%b want 0", wb_reg_write, wb_sel, wb_rd, illegal_o, stall_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_r_type();
    present(OP_R, 5'd3, 5'd1, 5'd2);
    tick();
    n_vec++; if (ex_alu_op !== 2'b10) begin n_err++; $display("FAIL r_ex_alu_op: got %b want 10", ex_alu_op); end
    n_vec++; if (ex_rd !== 5'd3) begin n_err++; $display("FAIL r_ex_rd: got %0d want 3", ex_rd); end
    n_vec++; if (ex_alu_src !== 1'b0) begin n_err++; $display("FAIL r_ex_alu_src: got %b want 0", ex_alu_src); end
    nop();
    tick();
    n_vec++; if (mem_rd !== 5'd3 || mem_read !== 1'b0) begin n_err++; $display("FAIL r_mem: got rd=%0d read=%b want 3,0", mem_rd, mem_read); end
    tick();
    n_vec++; if ({wb_reg_write, wb_sel, wb_rd} !== {1'b1, 2'b00, 5'd3}) begin
      n_err++; $display("FAIL r_wb: got we=%b sel=%b rd=%0d want 1,00,3", wb_reg_write, wb_sel, wb_rd); end
  endtask

  task automatic test_load_use();
    // ld x5 ; add x6,x5,x7
    present(OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    present(OP_R, 5'd6, 5'd5, 5'd7);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_add_stall: got %b want 1", stall_o); end
    tick();
    n_vec++; if ({ex_alu_src, ex_alu_op, ex_rd} !== '0) begin n_err++; $display("FAIL lu_add_bubble: got op=%b rd=%0d want 0", ex_alu_op, ex_rd); end
    n_vec++; if (mem_read !== 1'b1 || mem_rd !== 5'd5) begin n_err++; $display("FAIL lu_ld_in_mem: got read=%b rd=%0d want 1,5", mem_read, mem_rd); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_add_stall_clear: got %b want 0", stall_o); end
    tick();
    n_vec++; if (ex_alu_op !== 2'b10 || ex_rd !== 5'd6) begin n_err++; $display("FAIL lu_add_proceeds: got op=%b rd=%0d want 10,6", ex_alu_op, ex_rd); end
    // ld x5 ; sw x5,0(x1)  (x5 only as rs2)
    present(OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    present(OP_ST, 5'd9, 5'd1, 5'd5);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_sw_stall: got %b want 1", stall_o); end
    tick();
    n_vec++; if (ex_alu_src !== 1'b0 || stall_o !== 1'b0) begin n_err++; $display("FAIL lu_sw_bubble: got src=%b stall=%b want 0,0", ex_alu_src, stall_o); end
    tick();
    n_vec++; if (ex_alu_src !== 1'b1 || ex_rd !== 5'd0) begin n_err++; $display("FAIL lu_sw_proceeds: got src=%b rd=%0d want 1,0", ex_alu_src, ex_rd); end
    // ld x0 ; add x6,x0,x7 : no hazard through x0
    present(OP_LD, 5'd0, 5'd1, 5'd0);
    tick();
    n_vec++; if (ex_rd !== 5'd0) begin n_err++; $display("FAIL lu_x0_ex_rd: got %0d want 0", ex_rd); end
    present(OP_R, 5'd6, 5'd0, 5'd7);
    #1;
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_x0_stall: got %b want 0", stall_o); end
    nop();
    repeat (3) tick();
  endtask

  task automatic test_flush();
    present(OP_BR, 5'd0, 5'd1, 5'd2);
    tick();
    n_vec++; if (ex_alu_op !== 2'b01) begin n_err++; $display("FAIL fl_br_ex_alu_op: got %b want 01", ex_alu_op); end
    present(OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    n_vec++; if (mem_branch !== 1'b1) begin n_err++; $display("FAIL fl_br_in_mem: got %b want 1", mem_branch); end
    present(OP_R, 5'd6, 5'd5, 5'd7);
    flush_i = 1'b1;
    #1;
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall_suppressed: got %b want 0", stall_o); end
    tick();
    flush_i = 1'b0;
    nop();
    n_vec++; if ({ex_alu_src, ex_alu_op, ex_rd} !== '0) begin n_err++; $display("FAIL fl_ex_bubble: got op=%b rd=%0d want 0", ex_alu_op, ex_rd); end
    n_vec++; if ({mem_branch, mem_jump, mem_read, mem_write, mem_rd} !== '0) begin n_err++; $display("FAIL fl_mem_bubble: got read=%b rd=%0d want 0", mem_read, mem_rd); end
    n_vec++; if ({wb_reg_write, wb_sel, wb_rd} !== '0) begin n_err++; $display("FAIL fl_wb_branch: got we=%b sel=%b rd=%0d want 0", wb_reg_write, wb_sel, wb_rd); end
    repeat (3) tick();
  endtask

  task automatic test_x0_write();
    present(OP_R, 5'd0, 5'd1, 5'd2);
    tick();
    n_vec++; if (ex_rd !== 5'd0 || ex_alu_op !== 2'b10) begin n_err++; $display("FAIL x0_ex: got rd=%0d op=%b want 0,10", ex_rd, ex_alu_op); end
    nop();
    repeat (2) tick();
    n_vec++; if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0) begin n_err++; $display("FAIL x0_wb: got we=%b rd=%0d want 0,0", wb_reg_write, wb_rd); end
  endtask

  task automatic test_mode_illegal();
    present(OP_IMM, 5'd4, 5'd1, 5'd0);
    tick();
    n_vec++; if (b_ex_alu_op !== 2'b11) begin n_err++; $display("FAIL mode_funct_alu_op: got %b want 11", b_ex_alu_op); end
    n_vec++; if (ex_alu_op !== 2'b00 || ex_rd !== 5'd4) begin n_err++; $display("FAIL mode_add_alu_op: got op=%b rd=%0d want 00,4", ex_alu_op, ex_rd); end
    n_vec++; if (b_illegal !== 1'b0) begin n_err++; $display("FAIL mode_no_illegal: got %b want 0", b_illegal); end
    present(OP_JAL, 5'd1, 5'd0, 5'd0);
    tick();
    nop();
    n_vec++; if ({b_ex_alu_src, b_ex_alu_op, b_ex_rd} !== '0 || b_illegal !== 1'b1) begin
      n_err++; $display("FAIL ill_jal_disabled: got op=%b rd=%0d ill=%b want 0,0,1", b_ex_alu_op, b_ex_rd, b_illegal); end
    n_vec++; if (illegal_o !== 1'b0) begin n_err++; $display("FAIL ill_jal_enabled: got %b want 0", illegal_o); end
    repeat (3) tick();
    n_vec++; if (b_illegal !== 1'b1 || {b_wb_reg_write, b_wb_sel, b_wb_rd} !== '0) begin
      n_err++; $display("FAIL ill_sticky: got ill=%b we=%b sel=%b rd=%0d want 1,0,0,0", b_illegal, b_wb_reg_write, b_wb_sel, b_wb_rd); end
  endtask

  task automatic test_jump();
    present(OP_JAL, 5'd1, 5'd0, 5'd0);
    tick();
    n_vec++; if (ex_rd !== 5'd1 || ex_alu_src !== 1'b0) begin n_err++; $display("FAIL jal_ex: got rd=%0d src=%b want 1,0", ex_rd, ex_alu_src); end
    nop();
    tick();
    n_vec++; if (mem_jump !== 1'b1 || mem_rd !== 5'd1) begin n_err++; $display("FAIL jal_mem: got jump=%b rd=%0d want 1,1", mem_jump, mem_rd); end
    tick();
    n_vec++; if ({wb_reg_write, wb_sel, wb_rd} !== {1'b1, 2'b10, 5'd1}) begin
      n_err++; $display("FAIL jal_wb: got we=%b sel=%b rd=%0d want 1,10,1", wb_reg_write, wb_sel, wb_rd); end
    present(OP_BAD, 5'd7, 5'd1, 5'd2);
    tick();
    nop();
    n_vec++; if (illegal_o !== 1'b1 || {ex_alu_src, ex_alu_op, ex_rd} !== '0) begin
      n_err++; $display("FAIL bad_opcode: got ill=%b op=%b rd=%0d want 1,0,0", illegal_o, ex_alu_op, ex_rd); end
    tick();
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_use();
    test_flush();
    test_x0_write();
    test_mode_illegal();
    test_jump();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
